// File: rtl/prover_sum_pkg.sv
// Shared types and field helpers for the prover sum accumulator.
// Field width/modulus fall back to the 2^61-1 field when no field defines are supplied.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFFFFFFFFFFFFFF
`endif

package prover_sum_pkg;
    localparam int FW = `F_NBITS;
    localparam logic [FW-1:0] FQ = `F_Q;
    localparam int TAGB = 8;

    typedef enum logic {S_IDLE, S_ACC} state_t;

    typedef struct packed {
        logic [FW-1:0]   sum;
        logic [TAGB-1:0] tag;
    } entry_t;

    // Both operands are below q, so one conditional subtract suffices.
    function automatic logic [FW-1:0] mod_add(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [FW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, FQ}) s = s - {1'b0, FQ};
        return s[FW-1:0];
    endfunction
endpackage

// File: rtl/prover_sum_accum_if.sv
// Partial-sum input and result output handshake of prover_sum_accum.
interface prover_sum_accum_if
    import prover_sum_pkg::*;
#(parameter int ntagb = 8);
    logic             in_valid;
    logic [FW-1:0]    in;
    logic [ntagb-1:0] in_tag;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [FW-1:0]    out;
    logic [ntagb-1:0] out_tag;
    logic             idle;
    logic             err_ovf;
    logic             err_tag;

    modport master (output in_valid, in, in_tag, out_ready,
                    input  in_ready, out_valid, out, out_tag, idle, err_ovf, err_tag);
    modport slave  (input  in_valid, in, in_tag, out_ready,
                    output in_ready, out_valid, out, out_tag, idle, err_ovf, err_tag);
endinterface

// File: rtl/prover_sum_fifo.sv
// Result FIFO; a push while full is accepted only when a pop frees the head slot.
module prover_sum_fifo #(
    parameter int nfifo = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(nfifo);

    logic [W-1:0] mem [nfifo];
    logic [AW:0]  wp, rp;
    logic         do_push, do_pop;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Head is forced to zero when empty so the outputs are defined out of reset.
    assign rdata   = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rstb) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + (AW+1)'(1);
            if (do_pop)  rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/prover_sum_accum.sv
// Folds nchunks tagged partial sums mod q into one result and queues it for sumcheck.
// Optional build macro: PROVER_SUM_ACCUM_TAGCHK_EN (tag mismatch restarts the group).
module prover_sum_accum
    import prover_sum_pkg::*;
#(
    parameter int ntagb   = 8,
    parameter int nchunks = 4,
    parameter int nfifo   = 4
) (
    input logic               clk,
    input logic               rstb,
    prover_sum_accum_if.slave bus
);
    localparam int CW = $clog2(nchunks + 1);
    localparam int EW = FW + ntagb;

    state_t           state, state_n;
    logic [FW-1:0]    acc, acc_n, sum_s;
    logic [CW-1:0]    cnt, cnt_n;
    logic [ntagb-1:0] tag_r, tag_n;
    logic             last, tag_mis, push, pop, full, empty;
    logic [EW-1:0]    push_d, head;
    logic             err_ovf_r;

    assign sum_s = mod_add(acc, bus.in);
    assign last  = (cnt == CW'(nchunks - 1));
    assign pop   = ~empty & bus.out_ready;

`ifdef PROVER_SUM_ACCUM_TAGCHK_EN
    logic err_tag_r;
    assign tag_mis     = (state == S_ACC) && bus.in_valid && (bus.in_tag != tag_r);
    assign bus.err_tag = err_tag_r;
    always_ff @(posedge clk) begin
        if (rstb) err_tag_r <= 1'b0;
        else      err_tag_r <= err_tag_r | tag_mis;
    end
`else
    assign tag_mis     = 1'b0;
    assign bus.err_tag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rstb) begin
            state     <= S_IDLE;
            acc       <= '0;
            cnt       <= '0;
            tag_r     <= '0;
            err_ovf_r <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            tag_r     <= tag_n;
            // Tree has no backpressure: a full FIFO without a pop drops the result.
            err_ovf_r <= err_ovf_r | (push & full & ~pop);
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        tag_n   = tag_r;
        if (bus.in_valid) begin
            case (state)
                S_IDLE: begin
                    if (nchunks > 1) begin
                        acc_n   = bus.in;
                        tag_n   = bus.in_tag;
                        cnt_n   = CW'(1);
                        state_n = S_ACC;
                    end
                end
                S_ACC: begin
                    if (tag_mis) begin
                        acc_n = bus.in;
                        tag_n = bus.in_tag;
                        cnt_n = CW'(1);
                    end else if (last) begin
                        cnt_n   = '0;
                        state_n = S_IDLE;
                    end else begin
                        acc_n = sum_s;
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        push   = 1'b0;
        push_d = {sum_s, tag_r};
        if (bus.in_valid) begin
            case (state)
                S_IDLE: begin
                    if (nchunks == 1) begin
                        push   = 1'b1;
                        push_d = {bus.in, bus.in_tag};
                    end
                end
                S_ACC:   push = last & ~tag_mis;
                default: push = 1'b0;
            endcase
        end
    end

    prover_sum_fifo #(.nfifo(nfifo), .W(EW)) u_fifo (
        .clk   (clk),
        .rstb  (rstb),
        .push  (push),
        .pop   (pop),
        .wdata (push_d),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.out       = head[EW-1:ntagb];
    assign bus.out_tag   = head[ntagb-1:0];
    assign bus.idle      = (state == S_IDLE) && empty;
    assign bus.err_ovf   = err_ovf_r;
endmodule

// File: tb/tb_prover_sum_accum.sv
// Directed bench for prover_sum_accum (nchunks=4, nfifo=4, 2^61-1 field).
module tb_prover_sum_accum;
    import prover_sum_pkg::*;

    logic clk = 1'b0;
    logic rstb;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    prover_sum_accum_if #(.ntagb(8)) bus ();

    prover_sum_accum #(.ntagb(8), .nchunks(4), .nfifo(4)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [FW-1:0] v, input logic [7:0] t);
        bus.in_valid = 1'b1;
        bus.in       = v;
        bus.in_tag   = t;
        tick();
        bus.in_valid = 1'b0;
        bus.in       = '0;
    endtask

    task automatic group(input logic [FW-1:0] v, input logic [7:0] t);
        send(v, t); send('0, t); send('0, t); send('0, t);
    endtask

    task automatic pop_chk(input string tag, input logic [FW-1:0] v, input logic [7:0] t);
        chk({tag, "_vld"}, bus.out_valid, 1'b1);
        chk({tag, "_sum"}, bus.out, v);
        chk({tag, "_tag"}, bus.out_tag, t);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rstb = 1'b1;
        tick(); tick();
        rstb = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        do_reset();

        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_idle", bus.idle, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out", bus.out, 64'd0);
        chk("rst_out_tag", bus.out_tag, 64'd0);
        chk("rst_err_ovf", bus.err_ovf, 1'b0);
        chk("rst_err_tag", bus.err_tag, 1'b0);

        // Basic fold, back-to-back partials
        send(1, 7);
        chk("acc_busy", bus.idle, 1'b0);
        send(2, 7); send(3, 7);
        chk("acc_no_early", bus.out_valid, 1'b0);
        send(4, 7);
        pop_chk("sum10", 10, 7);
        chk("sum10_drained", bus.out_valid, 1'b0);
        chk("sum10_idle", bus.idle, 1'b1);

        // Modular wrap and s == q boundary
        send(FQ - 1, 1); send(2, 1); send(0, 1); send(0, 1);
        pop_chk("wrap", 1, 1);
        send(FQ - 1, 2); send(1, 2); send(0, 2); send(0, 2);
        pop_chk("eq_q", 0, 2);

        // Overflow with consumer stalled
        for (int g = 0; g < 3; g++) group(FW'(g + 1), 8'(10 + g));
        chk("ovf_ready_3", bus.in_ready, 1'b1);
        group(4, 13);
        chk("ovf_ready_4", bus.in_ready, 1'b0);
        chk("ovf_noerr_4", bus.err_ovf, 1'b0);
        group(5, 14);
        chk("ovf_err", bus.err_ovf, 1'b1);
        for (int g = 0; g < 4; g++) pop_chk("ovf_drain", FW'(g + 1), 8'(10 + g));
        chk("ovf_empty", bus.out_valid, 1'b0);
        chk("ovf_sticky", bus.err_ovf, 1'b1);

        do_reset();
        chk("rst2_err_ovf", bus.err_ovf, 1'b0);

        // Full FIFO, final chunk coincides with a pop
        for (int g = 0; g < 4; g++) group(FW'(g + 21), 8'(20 + g));
        chk("fp_full", bus.in_ready, 1'b0);
        chk("fp_head", bus.out, 64'd21);
        send(25, 24); send(0, 24); send(0, 24);
        bus.out_ready = 1'b1;
        send(0, 24);
        bus.out_ready = 1'b0;
        chk("fp_no_ovf", bus.err_ovf, 1'b0);
        chk("fp_still_full", bus.in_ready, 1'b0);
        for (int g = 1; g < 5; g++) pop_chk("fp_drain", FW'(g + 21), 8'(20 + g));
        chk("fp_empty", bus.out_valid, 1'b0);

        // Tag behaviour
`ifdef PROVER_SUM_ACCUM_TAGCHK_EN
        send(1, 3); send(1, 3); send(2, 5); send(2, 5); send(2, 5); send(2, 5);
        pop_chk("tagchk", 8, 5);
        chk("tagchk_single", bus.out_valid, 1'b0);
        chk("tagchk_err", bus.err_tag, 1'b1);
`else
        send(1, 3); send(1, 3); send(1, 5); send(1, 5);
        pop_chk("tagign", 4, 3);
        chk("tagign_err", bus.err_tag, 1'b0);
`endif

        // Reset mid-group discards the partial
        send(9, 6); send(9, 6);
        rstb = 1'b1;
        tick();
        chk("mid_rst_idle", bus.idle, 1'b1);
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        rstb = 1'b0;
        send(5, 9); send(6, 9); send(7, 9); send(8, 9);
        pop_chk("fresh", 26, 9);
        chk("fresh_idle", bus.idle, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
